// File: rtl/avalon_burst_copier_pkg.sv
// Shared types and constants for the Avalon-MM burst copier.
package avalon_burst_copier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR,
    FIN
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic int unsigned max_burst(input int unsigned burstcount_w);
    return 32'd1 << (burstcount_w - 1);
  endfunction

endpackage

// File: rtl/avalon_burst_copier_buf.sv
// Chunk staging buffer: MAX_BURST x DATA_W registers, one write port,
// one combinational read port.
module avalon_burst_copier_buf
  import avalon_burst_copier_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/avalon_burst_copier.sv
// Avalon-MM DMA copier: read burst into a local buffer, then write burst out.
// Optional AVALON_BURST_COPIER_CSUM_EN adds a running sum of written words.
module avalon_burst_copier
  import avalon_burst_copier_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BURSTCOUNT_W = 4,
  parameter int unsigned LEN_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cfg_src,
  input  logic [ADDR_W-1:0]       cfg_dst,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    cfg_start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       avm_address,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [DATA_W-1:0]       avm_writedata,
  output logic [DATA_W/8-1:0]     avm_byteenable,
  input  logic [DATA_W-1:0]       avm_readdata,
  input  logic                    avm_readdatavalid,
  input  logic                    avm_waitrequest
`ifdef AVALON_BURST_COPIER_CSUM_EN
  ,
  output logic [DATA_W-1:0]       csum
`endif
);

  localparam int unsigned MAX_BURST = max_burst(BURSTCOUNT_W);
  localparam int unsigned IDX_W     = BURSTCOUNT_W - 1;
  localparam logic [LEN_W-1:0]        LP_MAX_LEN = LEN_W'(MAX_BURST);
  localparam logic [BURSTCOUNT_W-1:0] LP_MAX_BC  = BURSTCOUNT_W'(MAX_BURST);
  localparam logic [BURSTCOUNT_W-1:0] LP_ONE     = BURSTCOUNT_W'(1);

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0]       r_src, r_dst;
  logic [LEN_W-1:0]        r_rem;
  logic [BURSTCOUNT_W-1:0] r_rd_k, r_wr_j;

  logic [BURSTCOUNT_W-1:0] w_burst;
  logic [LEN_W-1:0]        w_rem_nxt;
  logic [ADDR_W-1:0]       w_step;
  logic                    w_start;
  logic                    w_rd_cap, w_rd_last, w_rd_full;
  logic                    w_cmd_acc, w_wr_acc, w_wr_last;
  logic [DATA_W-1:0]       w_buf_rdata;
  logic [3:0]              w_unused_lsbs;

  assign w_unused_lsbs = {cfg_src[1:0], cfg_dst[1:0]};

  assign w_start   = (r_state == IDLE) && cfg_start;
  assign w_burst   = (r_rem >= LP_MAX_LEN) ? LP_MAX_BC : r_rem[BURSTCOUNT_W-1:0];
  assign w_rem_nxt = r_rem - LEN_W'(w_burst);
  assign w_step    = ADDR_W'(w_burst) * ADDR_W'(BYTES_PER_WORD);

  // Beats are captured in RD_REQ too, so one landing with command acceptance is kept.
  assign w_rd_cap  = avm_readdatavalid && ((r_state == RD_REQ) || (r_state == RD_DATA))
                     && (r_rd_k < w_burst);
  assign w_rd_last = w_rd_cap && (r_rd_k == (w_burst - LP_ONE));
  assign w_rd_full = (r_rd_k == w_burst);

  assign w_cmd_acc = (r_state == RD_REQ) && !avm_waitrequest;
  assign w_wr_acc  = (r_state == WR) && !avm_waitrequest;
  assign w_wr_last = w_wr_acc && (r_wr_j == (w_burst - LP_ONE));

  avalon_burst_copier_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_BURST),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_rd_cap),
    .i_widx  (r_rd_k[IDX_W-1:0]),
    .i_wdata (avm_readdata),
    .i_ridx  (r_wr_j[IDX_W-1:0]),
    .o_rdata (w_buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    busy           = 1'b0;
    done           = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_burstcount = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    unique case (r_state)
      IDLE: begin
        if (cfg_start) begin
          w_state_nxt = (cfg_len != '0) ? RD_REQ : FIN;
        end
      end
      RD_REQ: begin
        busy           = 1'b1;
        avm_read       = 1'b1;
        avm_address    = r_src;
        avm_burstcount = w_burst;
        if (w_cmd_acc) begin
          w_state_nxt = w_rd_last ? WR : RD_DATA;
        end
      end
      RD_DATA: begin
        busy = 1'b1;
        if (w_rd_last || w_rd_full) begin
          w_state_nxt = WR;
        end
      end
      WR: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_address    = r_dst;
        avm_burstcount = w_burst;
        avm_writedata  = w_buf_rdata;
        avm_byteenable = '1;
        if (w_wr_last) begin
          w_state_nxt = (w_rem_nxt == '0) ? FIN : RD_REQ;
        end
      end
      FIN: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_rem  <= '0;
      r_rd_k <= '0;
      r_wr_j <= '0;
    end else begin
      if (w_start) begin
        r_src  <= {cfg_src[ADDR_W-1:2], 2'b00};
        r_dst  <= {cfg_dst[ADDR_W-1:2], 2'b00};
        r_rem  <= cfg_len;
        r_rd_k <= '0;
        r_wr_j <= '0;
      end
      if (w_rd_cap) begin
        r_rd_k <= r_rd_k + LP_ONE;
      end
      if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wr_j <= '0;
          r_rd_k <= '0;
          r_src  <= r_src + w_step;
          r_dst  <= r_dst + w_step;
          r_rem  <= w_rem_nxt;
        end else begin
          r_wr_j <= r_wr_j + LP_ONE;
        end
      end
    end
  end

`ifdef AVALON_BURST_COPIER_CSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if (w_wr_acc) begin
      r_csum <= r_csum + w_buf_rdata;
    end
  end

  assign csum = r_csum;
`endif

endmodule

// File: tb/tb_avalon_burst_copier.sv
// Self-checking bench for avalon_burst_copier: memory agent plus chunk-level
// reference model; csum checks are compiled with AVALON_BURST_COPIER_CSUM_EN.
module tb_avalon_burst_copier;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BCW  = 4;
  localparam int unsigned LW   = 16;
  localparam int unsigned MAXB = 8;
  localparam int unsigned MEMW = 1024;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [3:0]  n;
  } chunk_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   cfg_src = '0;
  logic [AW-1:0]   cfg_dst = '0;
  logic [LW-1:0]   cfg_len = '0;
  logic            cfg_start = 1'b0;
  logic            busy, done, avm_read, avm_write;
  logic [AW-1:0]   avm_address;
  logic [BCW-1:0]  avm_burstcount;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic [DW-1:0]   avm_readdata = '0;
  logic            avm_readdatavalid = 1'b0;
  logic            avm_waitrequest = 1'b0;
`ifdef AVALON_BURST_COPIER_CSUM_EN
  logic [DW-1:0]   csum;
`endif

  always #5 clk = ~clk;

  avalon_burst_copier #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .BURSTCOUNT_W (BCW),
    .LEN_W        (LW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_src           (cfg_src),
    .cfg_dst           (cfg_dst),
    .cfg_len           (cfg_len),
    .cfg_start         (cfg_start),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
`ifdef AVALON_BURST_COPIER_CSUM_EN
    ,
    .csum              (csum)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] mem [MEMW];
  logic [31:0] rd_beats [$];
  chunk_t      exp_rd_q [$];
  chunk_t      exp_wr_q [$];
  int unsigned wr_beat = 0;
  int unsigned done_cnt = 0;
  int unsigned rd_cmds = 0;
  int unsigned wr_total = 0;
  int unsigned bus_cycles = 0;
  logic [31:0] last_rd_addr = '0;
  logic [3:0]  last_rd_bc = '0;
  bit          stall_en = 1'b0;
  bit          gap_en = 1'b0;
  bit          saw_done = 1'b0;
  logic        p_stall_rd = 1'b0;
  logic        p_stall_wr = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wd = '0;
  logic [3:0]  p_bc = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return 32'(a[11:2]);
  endfunction

  // Reference: split the copy into min(remaining, MAXB)-word chunks.
  task automatic plan_copy(input logic [31:0] src, input logic [31:0] dst, input int unsigned len);
    logic [31:0] s;
    logic [31:0] d;
    int unsigned rem;
    int unsigned n;
    chunk_t c;
    s = src & ~32'd3;
    d = dst & ~32'd3;
    rem = len;
    while (rem > 0) begin
      n = (rem > MAXB) ? MAXB : rem;
      c.src = s;
      c.dst = d;
      c.n = 4'(n);
      exp_rd_q.push_back(c);
      exp_wr_q.push_back(c);
      s = s + 32'(4 * n);
      d = d + 32'(4 * n);
      rem = rem - n;
    end
  endtask

  // One clock: agent response and protocol/model checks at negedge, then return after posedge.
  task automatic step();
    chunk_t c;
    logic [31:0] expw;
    @(negedge clk);
    if (reset) begin
      rd_beats.delete();
      exp_rd_q.delete();
      exp_wr_q.delete();
      wr_beat = 0;
      avm_readdatavalid = 1'b0;
      avm_waitrequest = 1'b0;
      p_stall_rd = 1'b0;
      p_stall_wr = 1'b0;
    end else begin
      if (p_stall_rd)
        check("hold_rd_cmd", 64'({avm_read, avm_address, avm_burstcount}), 64'({1'b1, p_addr, p_bc}));
      if (p_stall_wr) begin
        check("hold_wr_cmd", 64'({avm_write, avm_address, avm_burstcount}), 64'({1'b1, p_addr, p_bc}));
        check("hold_wr_data", 64'(avm_writedata), 64'(p_wd));
      end
      if (avm_read || avm_write) begin
        bus_cycles++;
        check("rd_wr_exclusive", 64'(avm_read & avm_write), 64'd0);
      end
      if (avm_write) check("byteenable", 64'(avm_byteenable), 64'hF);
      if (done) begin
        saw_done = 1'b1;
        done_cnt++;
        check("busy_low_at_done", 64'(busy), 64'd0);
      end

      if (rd_beats.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = rd_beats.pop_front();
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom();
      end
      avm_waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;

      if (avm_read && !avm_waitrequest) begin
        rd_cmds++;
        last_rd_addr = avm_address;
        last_rd_bc = avm_burstcount;
        if (exp_rd_q.size() == 0) begin
          check("rd_cmd_expected", 64'(exp_rd_q.size()), 64'd1);
        end else begin
          c = exp_rd_q.pop_front();
          check("rd_addr", 64'(avm_address), 64'(c.src));
          check("rd_burstcount", 64'(avm_burstcount), 64'(c.n));
        end
        for (int i = 0; i < int'(avm_burstcount); i++)
          rd_beats.push_back(mem[widx(avm_address + 32'(4 * i))]);
      end

      if (avm_write && !avm_waitrequest) begin
        wr_total++;
        if (exp_wr_q.size() == 0) begin
          check("wr_beat_expected", 64'(exp_wr_q.size()), 64'd1);
        end else begin
          c = exp_wr_q[0];
          expw = mem[widx(c.src + 32'(4 * wr_beat))];
          check("wr_addr", 64'(avm_address), 64'(c.dst));
          check("wr_burstcount", 64'(avm_burstcount), 64'(c.n));
          check("wr_data", 64'(avm_writedata), 64'(expw));
          mem[widx(c.dst + 32'(4 * wr_beat))] = avm_writedata;
          wr_beat++;
          if (wr_beat == 32'(c.n)) begin
            wr_beat = 0;
            void'(exp_wr_q.pop_front());
          end
        end
      end

      p_stall_rd = avm_read && avm_waitrequest;
      p_stall_wr = avm_write && avm_waitrequest;
      p_addr = avm_address;
      p_bc = avm_burstcount;
      p_wd = avm_writedata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int unsigned len);
    plan_copy(src, dst, len);
    saw_done = 1'b0;
    cfg_src = src;
    cfg_dst = dst;
    cfg_len = LW'(len);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input int unsigned len,
                         input bit tp_check, input bit poke);
    int unsigned cyc;
    int unsigned d0;
    int unsigned bound;
    int unsigned rem;
    int unsigned n;
    logic [31:0] snap [$];
    logic [31:0] sum;
    cyc = 0;
    d0 = done_cnt;
    sum = '0;
    for (int unsigned i = 0; i < len; i++) begin
      snap.push_back(mem[widx((src & ~32'd3) + 32'(4 * i))]);
      sum = sum + mem[widx((src & ~32'd3) + 32'(4 * i))];
    end
    bound = 2;
    rem = len;
    while (rem > 0) begin
      n = (rem > MAXB) ? MAXB : rem;
      bound = bound + 2 * n + 2;
      rem = rem - n;
    end
    start_copy(src, dst, len);
    if (len != 0) check("busy_after_start", 64'(busy), 64'd1);
    while (!saw_done && cyc < 4000) begin
      if (poke && cyc == 4) begin
        cfg_src = 32'hFFF0;
        cfg_dst = 32'h0;
        cfg_len = 16'd3;
        cfg_start = 1'b1;
      end
      step();
      cyc++;
      cfg_start = 1'b0;
    end
    check("done_seen", 64'(saw_done), 64'd1);
    if (tp_check) check("latency_within_bound", 64'(cyc <= bound), 64'd1);
    repeat (3) step();
    check("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    check("chunks_drained", 64'(exp_rd_q.size() + exp_wr_q.size()), 64'd0);
    for (int unsigned i = 0; i < len; i++)
      check("mem_dst", 64'(mem[widx((dst & ~32'd3) + 32'(4 * i))]), 64'(snap[i]));
`ifdef AVALON_BURST_COPIER_CSUM_EN
    check("csum_after_done", 64'(csum), 64'(sum));
`endif
  endtask

  initial begin
    int unsigned r0;
    int unsigned w0;
    int unsigned b0;
    int unsigned d0;
    bit found;
    logic [31:0] s;
    logic [31:0] d;

    for (int i = 0; i < int'(MEMW); i++) mem[i] = $urandom();

    reset = 1'b1;
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_read", 64'(avm_read), 64'd0);
    check("rst_write", 64'(avm_write), 64'd0);
    check("rst_address", 64'(avm_address), 64'd0);
    check("rst_burstcount", 64'(avm_burstcount), 64'd0);
    check("rst_writedata", 64'(avm_writedata), 64'd0);
    reset = 1'b0;
    step();

    // Single full burst with hand-computed destination contents.
    for (int i = 0; i < 8; i++) mem[i] = 32'hA0 + 32'(i);
    r0 = rd_cmds;
    do_copy(32'h000, 32'h100, 8, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) check("t1_dst_literal", 64'(mem[32'h40 + i]), 64'(32'hA0 + 32'(i)));
    check("t1_read_cmds", 64'(rd_cmds - r0), 64'd1);
    check("t1_burstcount", 64'(last_rd_bc), 64'd8);

    // 19 words: 8 + 8 + 3, third read at byte 0x40.
    r0 = rd_cmds;
    do_copy(32'h000, 32'h200, 19, 1'b1, 1'b0);
    check("t2_read_cmds", 64'(rd_cmds - r0), 64'd3);
    check("t2_last_rd_addr", 64'(last_rd_addr), 64'h40);
    check("t2_last_rd_bc", 64'(last_rd_bc), 64'd3);

    // Zero length: done without any bus traffic.
    r0 = rd_cmds;
    w0 = wr_total;
    b0 = bus_cycles;
    do_copy(32'h010, 32'h300, 0, 1'b1, 1'b0);
    check("t3_no_reads", 64'(rd_cmds - r0), 64'd0);
    check("t3_no_writes", 64'(wr_total - w0), 64'd0);
    check("t3_no_bus_cycles", 64'(bus_cycles - b0), 64'd0);

    // Random stalls and read gaps, with a start pulse poked mid-copy.
    stall_en = 1'b1;
    gap_en = 1'b1;
    do_copy(32'h300, 32'h500, 10, 1'b0, 1'b1);
    stall_en = 1'b0;
    gap_en = 1'b0;

    // Reset during the third write beat.
    start_copy(32'h080, 32'h600, 8);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (avm_write && wr_beat == 2) found = 1'b1;
    end
    check("t5_reached_third_beat", 64'(found), 64'd1);
    d0 = done_cnt;
    reset = 1'b1;
    step();
    check("t5_write_low", 64'(avm_write), 64'd0);
    check("t5_read_low", 64'(avm_read), 64'd0);
    check("t5_busy_low", 64'(busy), 64'd0);
    check("t5_done_low", 64'(done), 64'd0);
    check("t5_address", 64'(avm_address), 64'd0);
    check("t5_burstcount", 64'(avm_burstcount), 64'd0);
    check("t5_writedata", 64'(avm_writedata), 64'd0);
    reset = 1'b0;
    repeat (4) step();
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    do_copy(32'h080, 32'h700, 4, 1'b1, 1'b0);

    // Randomised copies with unaligned address bits.
    for (int k = 0; k < 6; k++) begin
      stall_en = ($urandom_range(0, 1) == 1);
      gap_en = stall_en;
      s = 32'(4 * $urandom_range(0, 200)) + 32'($urandom_range(0, 3));
      d = 32'(4 * $urandom_range(512, 700)) + 32'($urandom_range(0, 3));
      do_copy(s, d, $urandom_range(1, 40), !stall_en, 1'b0);
    end
    stall_en = 1'b0;
    gap_en = 1'b0;

`ifdef AVALON_BURST_COPIER_CSUM_EN
    mem[32'h3C0 >> 2] = 32'd1;
    mem[(32'h3C0 >> 2) + 1] = 32'd2;
    mem[(32'h3C0 >> 2) + 2] = 32'd3;
    mem[(32'h3C0 >> 2) + 3] = 32'hFFFF_FFFF;
    do_copy(32'h3C0, 32'hF00, 4, 1'b1, 1'b0);
    check("csum_literal", 64'(csum), 64'h5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
